// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: shared definitions for the shift register command sequencer.
//   - MODE_* : S1/S0 select encodings of the downstream 4-bit bidirectional
//              shift register (also the CMD_OP encodings).
//   - state_e: controller FSM states.
package shift_ctrl_pkg;

  localparam logic [1:0] MODE_ROT_UP = 2'b00;
  localparam logic [1:0] MODE_ROT_DN = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b10;
  localparam logic [1:0] MODE_LOAD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step_counter.sv
// shift_step_counter: CNT_W-bit loadable down-counter that tracks the
// remaining active-mode edges of a command.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load         : load i_load_val (wins over decrement)
//   i_load_val     : step count to load
//   i_dec          : decrement by one (saturates at 0)
//   o_last         : count == 1, i.e. the current edge is the final step
module shift_step_counter #(
  parameter int CNT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                r_cnt <= '0;
    else if (i_load)             r_cnt <= i_load_val;
    else if (i_dec && |r_cnt)    r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign o_last = (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/shift_register_controller.sv
// shift_register_controller: command sequencer for a WIDTH-bit bidirectional
// shift register. Accepts load / rotate-up-by-N / rotate-down-by-N / no-op
// commands on a valid/ready handshake, drives the register's S1/S0 selects
// and D inputs for exactly the required number of edges, then captures Q
// into RESULT and pulses DONE.
// Ports:
//   CLK, RSTn          : clock, async active-low reset
//   CMD_VALID/READY    : command handshake
//   CMD_OP/CNT/DATA    : operation, rotate step count, load value
//   S1, S0, D          : registered controls to the shift register
//   Q                  : shift register outputs fed back
//   BUSY, DONE, RESULT : status, one-cycle completion pulse, captured Q
//   MISMATCH           : sticky shadow-model disagreement flag
// Optional: define SHIFT_SHADOW_CHECK_EN to build a shadow copy of the
// register that is compared to Q at the end of each command; otherwise
// MISMATCH is tied low.
module shift_register_controller
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [CNT_W-1:0] CMD_CNT,
  input  logic [WIDTH-1:0] CMD_DATA,
  output logic             S1,
  output logic             S0,
  output logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] Q,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             MISMATCH
);

  state_e           r_state;
  logic [1:0]       r_sel;
  logic [WIDTH-1:0] r_d;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  logic             w_accept;
  logic             w_is_rot;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_val;
  logic             w_last;

  // Ready is gated by RSTn so the source never sees a handshake while held in reset.
  assign CMD_READY  = (r_state == IDLE) && RSTn;
  assign w_accept   = CMD_VALID && CMD_READY;
  assign w_is_rot   = (CMD_OP == MODE_ROT_UP) || (CMD_OP == MODE_ROT_DN);
  // Only commands that need active edges load the counter; a load is one edge.
  assign w_cnt_load = w_accept && ((CMD_OP == MODE_LOAD) || (w_is_rot && |CMD_CNT));
  assign w_cnt_val  = (CMD_OP == MODE_LOAD) ? {{(CNT_W-1){1'b0}}, 1'b1} : CMD_CNT;

  shift_step_counter #(.CNT_W(CNT_W)) u_cnt (
    .i_clk      (CLK),
    .i_rst_n    (RSTn),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (r_state == SHIFT),
    .o_last     (w_last)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state  <= IDLE;
      r_sel    <= MODE_HOLD;
      r_d      <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (CMD_OP == MODE_LOAD) begin
              r_sel   <= MODE_LOAD;
              r_d     <= CMD_DATA;
              r_state <= SHIFT;
            end else if (w_is_rot && |CMD_CNT) begin
              r_sel   <= CMD_OP;
              r_state <= SHIFT;
            end else begin
              // no-op or zero-count rotate: nothing to drive, complete next cycle
              r_done  <= 1'b1;
              r_state <= FINISH;
            end
          end
        end
        SHIFT: begin
          // the edge that sees count==1 is the last active edge; drop to hold after it
          if (w_last) begin
            r_sel   <= MODE_HOLD;
            r_d     <= '0;
            r_done  <= 1'b1;
            r_state <= FINISH;
          end
        end
        FINISH: begin
          r_done   <= 1'b0;
          r_result <= Q;
          r_state  <= IDLE;
        end
        default: begin
          r_sel   <= MODE_HOLD;
          r_d     <= '0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign S1     = r_sel[1];
  assign S0     = r_sel[0];
  assign D      = r_d;
  assign BUSY   = (r_state != IDLE);
  assign DONE   = r_done;
  assign RESULT = r_result;

`ifdef SHIFT_SHADOW_CHECK_EN
  logic [WIDTH-1:0] r_shadow;
  logic             r_mismatch;

  // Shadow applies the same select/data the register sees on every SHIFT edge.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_shadow   <= '0;
      r_mismatch <= 1'b0;
    end else begin
      if (r_state == SHIFT) begin
        case (r_sel)
          MODE_ROT_UP: r_shadow <= {r_shadow[WIDTH-2:0], r_shadow[WIDTH-1]};
          MODE_ROT_DN: r_shadow <= {r_shadow[0], r_shadow[WIDTH-1:1]};
          MODE_LOAD:   r_shadow <= r_d;
          default:     r_shadow <= r_shadow;
        endcase
      end
      // sticky until reset
      if ((r_state == FINISH) && (r_shadow != Q)) r_mismatch <= 1'b1;
    end
  end

  assign MISMATCH = r_mismatch;
`else
  assign MISMATCH = 1'b0;
`endif

endmodule

// File: tb/tb_shift_register_controller.sv
module tb_shift_register_controller;

`ifdef SHIFT_SHADOW_CHECK_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic [1:0] CMD_OP = 2'b10;
  logic [2:0] CMD_CNT = 3'd0;
  logic [3:0] CMD_DATA = 4'd0;
  logic       S1, S0;
  logic [3:0] D;
  logic [3:0] Q;
  logic       BUSY, DONE;
  logic [3:0] RESULT;
  logic       MISMATCH;

  shift_register_controller #(.WIDTH(4), .CNT_W(3)) dut (
    .CLK(CLK), .RSTn(RSTn), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_CNT(CMD_CNT), .CMD_DATA(CMD_DATA),
    .S1(S1), .S0(S0), .D(D), .Q(Q), .BUSY(BUSY), .DONE(DONE),
    .RESULT(RESULT), .MISMATCH(MISMATCH)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // behavioural 4-bit bidirectional shift register (not reset by RSTn)
  logic [3:0] r_q = 4'b0000;
  bit         corrupt = 1'b0;
  always @(posedge CLK) begin
    case ({S1, S0})
      2'b00:   r_q <= {r_q[2:0], r_q[3]};
      2'b01:   r_q <= {r_q[0], r_q[3:1]};
      2'b11:   r_q <= D;
      default: r_q <= r_q;
    endcase
  end
  assign Q = r_q ^ ((corrupt && DONE) ? 4'b0001 : 4'b0000);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         t0;
    int         lat;
    int         act;
    logic [1:0] mode;
    logic [3:0] res;
    logic       mm;
  } exp_t;

  exp_t exp_q[$];

  // Drives a command, waits (bounded) for acceptance, pushes its expectation.
  task automatic send(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data,
                      input int lat, input int act, input logic [3:0] res, input logic mm,
                      output int t0);
    exp_t it;
    bit ok = 1'b0;
    CMD_OP = op; CMD_CNT = cnt; CMD_DATA = data; CMD_VALID = 1'b1;
    t0 = -1;
    for (int i = 0; i < 200; i++) begin
      if (CMD_READY) begin ok = 1'b1; break; end
      chk("busy_while_not_ready", BUSY, 1);
      @(negedge CLK);
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      CMD_VALID = 1'b0;
      return;
    end
    t0 = cyc + 1;
    it.t0 = t0; it.lat = lat; it.act = act; it.mode = op; it.res = res; it.mm = mm;
    exp_q.push_back(it);
    @(posedge CLK);
    #1 CMD_VALID = 1'b0;
  endtask

  // Monitor / scoreboard
  int   busy_cnt = 0;
  int   act_cnt = 0;
  bit   chk_res = 1'b0;
  exp_t cur;

  always @(negedge CLK) begin
    if (!RSTn) begin
      busy_cnt = 0; act_cnt = 0; chk_res = 1'b0;
    end else begin
      if (chk_res) begin
        chk("result", RESULT, cur.res);
        chk("shadow_flag", MISMATCH, cur.mm);
        chk("ready_after_done", CMD_READY, 1);
        chk_res = 1'b0;
      end
      if (BUSY) busy_cnt++;
      if ({S1, S0} != 2'b10) begin
        act_cnt++;
        if (exp_q.size() > 0) chk("mode", {S1, S0}, exp_q[0].mode);
        else chk("mode_when_idle", {S1, S0}, 2'b10);
      end
      if (DONE) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          cur = exp_q.pop_front();
          chk("latency", cyc + 1 - cur.t0, cur.lat);
          chk("active_cycles", act_cnt, cur.act);
          chk("busy_cycles", busy_cnt, cur.lat);
          chk_res = 1'b1;
        end
        busy_cnt = 0; act_cnt = 0;
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_s", {S1, S0}, 2'b10);
    chk("rst_d", D, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_result", RESULT, 0);
    chk("rst_shadow_flag", MISMATCH, 0);
    chk("rst_ready", CMD_READY, 0);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2 RSTn = 1'b0;
    exp_q.delete();
    #1 check_reset_vals();
    @(posedge CLK);
    #2 RSTn = 1'b1;
    #1 chk("ready_after_reset", CMD_READY, 1);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && !chk_res) begin ok = 1'b1; break; end
      @(negedge CLK);
    end
    if (!ok) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, ta, tb;
    // power-on reset
    repeat (2) @(posedge CLK);
    #1 check_reset_vals();
    #1 RSTn = 1'b1;
    #1 chk("ready_after_por", CMD_READY, 1);
    repeat (3) @(posedge CLK);
    // reset mid-idle, then load 1011
    do_reset();
    send(2'b11, 3'd0, 4'b1011, 2, 1, 4'b1011, 1'b0, t0);
    drain();
    // rotate up by 3 from 0001
    send(2'b11, 3'd0, 4'b0001, 2, 1, 4'b0001, 1'b0, t0);
    send(2'b00, 3'd3, 4'b1111, 4, 3, 4'b1000, 1'b0, t0);
    drain();
    // rotate down by 5 from 0001 (wraps)
    send(2'b11, 3'd0, 4'b0001, 2, 1, 4'b0001, 1'b0, t0);
    send(2'b01, 3'd5, 4'b0000, 6, 5, 4'b1000, 1'b0, t0);
    drain();
    // zero-count rotate and no-op
    send(2'b00, 3'd0, 4'b0101, 1, 0, 4'b1000, 1'b0, t0);
    send(2'b10, 3'd5, 4'b1111, 1, 0, 4'b1000, 1'b0, t0);
    drain();
    // second command held valid while the first is in progress
    send(2'b11, 3'd0, 4'b0011, 2, 1, 4'b0011, 1'b0, ta);
    send(2'b01, 3'd2, 4'b0000, 3, 2, 4'b1100, 1'b0, tb);
    chk("held_accept_gap", tb - ta, 3);
    drain();
    // reset in the middle of a 6-step rotate
    send(2'b11, 3'd0, 4'b0101, 2, 1, 4'b0101, 1'b0, t0);
    send(2'b00, 3'd6, 4'b0000, 7, 6, 4'b0000, 1'b0, t0);
    repeat (3) @(posedge CLK);
    #1 chk("busy_mid_rotate", BUSY, 1);
    do_reset();
    // corrupt Q during FINISH: flag only with the shadow built
    corrupt = 1'b1;
    send(2'b11, 3'd0, 4'b0110, 2, 1, 4'b0111, SH, t0);
    drain();
    corrupt = 1'b0;
    send(2'b10, 3'd0, 4'b0000, 1, 0, 4'b0110, SH, t0);
    drain();
    do_reset();
    send(2'b11, 3'd0, 4'b1110, 2, 1, 4'b1110, 1'b0, t0);
    drain();
    repeat (2) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
